// File: rtl/gcn_mac_sequencer.sv
// Control sequencer for the GCN feature x weight MAC: issues buffer reads, steers the shared
// accumulator, commits each result and drains them downstream. Optional counters: GCN_SEQ_PERF_EN.
module gcn_mac_sequencer #(
   parameter int unsigned ROWS   = 96,
   parameter int unsigned COLS   = 3,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned ROW_W  = 7,
   parameter int unsigned COL_W  = 2,
   parameter int unsigned IDX_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             rd_en,
   output logic [ROW_W-1:0] row_addr,
   output logic [COL_W-1:0] feat_col,
   output logic [COL_W-1:0] wgt_col,
   output logic             mac_en,
   output logic             mac_first,
   output logic             acc_wr,
   output logic [IDX_W-1:0] acc_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx
`ifdef GCN_SEQ_PERF_EN
   ,
   output logic [15:0]      perf_cycles,
   output logic [15:0]      perf_stall
`endif
);

   localparam int unsigned FL_W = 2;
   localparam int unsigned NRES = COLS * COLS;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_FLUSH = 3'd2;
   localparam logic [2:0] S_WB    = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]       state_q, state_d;
   logic [ROW_W-1:0] k_q, k_d;
   logic [COL_W-1:0] i_q, i_d;
   logic [COL_W-1:0] j_q, j_d;
   logic [IDX_W-1:0] e_q, e_d;
   logic [IDX_W-1:0] d_q, d_d;
   logic [FL_W-1:0]  fl_q, fl_d;

   logic             rd_en_q, acc_wr_q, out_valid_q, busy_q, done_q;
   logic [RD_LAT-1:0] en_pipe_q, first_pipe_q;

   logic             kill_c;
   logic             start_acc_c;

   // Abort only acts outside IDLE; start is refused when abort arrives with it.
   assign kill_c      = abort && (state_q != S_IDLE);
   assign start_acc_c = (state_q == S_IDLE) && start && !abort;

   // Next-state and counter logic
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      i_d     = i_q;
      j_d     = j_q;
      e_d     = e_q;
      d_d     = d_q;
      fl_d    = fl_q;

      case (state_q)
         S_IDLE: begin
            if (start_acc_c) begin
               state_d = S_ISSUE;
               k_d     = '0;
               i_d     = '0;
               j_d     = '0;
               e_d     = '0;
               d_d     = '0;
               fl_d    = '0;
            end
         end
         S_ISSUE: begin
            if (k_q == ROW_W'(ROWS - 1)) begin
               k_d     = '0;
               fl_d    = '0;
               state_d = S_FLUSH;
            end else begin
               k_d = k_q + ROW_W'(1);
            end
         end
         S_FLUSH: begin
            if (fl_q == FL_W'(RD_LAT - 1)) begin
               fl_d    = '0;
               state_d = S_WB;
            end else begin
               fl_d = fl_q + FL_W'(1);
            end
         end
         S_WB: begin
            // j is the inner loop; e tracks i*COLS+j without a multiplier
            if (j_q == COL_W'(COLS - 1)) begin
               j_d = '0;
               if (i_q == COL_W'(COLS - 1)) begin
                  i_d     = '0;
                  e_d     = '0;
                  state_d = S_DRAIN;
               end else begin
                  i_d     = i_q + COL_W'(1);
                  e_d     = e_q + IDX_W'(1);
                  state_d = S_ISSUE;
               end
            end else begin
               j_d     = j_q + COL_W'(1);
               e_d     = e_q + IDX_W'(1);
               state_d = S_ISSUE;
            end
         end
         S_DRAIN: begin
            if (out_ready) begin
               if (d_q == IDX_W'(NRES - 1)) begin
                  d_d     = '0;
                  state_d = S_DONE;
               end else begin
                  d_d = d_q + IDX_W'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (kill_c) begin
         state_d = S_IDLE;
         k_d     = '0;
         i_d     = '0;
         j_d     = '0;
         e_d     = '0;
         d_d     = '0;
         fl_d    = '0;
      end
   end

   // State, counters and registered strobes decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         i_q         <= '0;
         j_q         <= '0;
         e_q         <= '0;
         d_q         <= '0;
         fl_q        <= '0;
         rd_en_q     <= 1'b0;
         acc_wr_q    <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         i_q         <= i_d;
         j_q         <= j_d;
         e_q         <= e_d;
         d_q         <= d_d;
         fl_q        <= fl_d;
         rd_en_q     <= (state_d == S_ISSUE);
         acc_wr_q    <= (state_d == S_WB);
         out_valid_q <= (state_d == S_DRAIN);
         busy_q      <= (state_d != S_IDLE);
         done_q      <= (state_d == S_DONE);
      end
   end

   // Read-latency delay line: the k==0 flag rides with rd_en to mark the accumulator load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_pipe_q    <= '0;
         first_pipe_q <= '0;
      end else if (kill_c) begin
         en_pipe_q    <= '0;
         first_pipe_q <= '0;
      end else begin
         en_pipe_q    <= RD_LAT'({en_pipe_q, rd_en_q});
         first_pipe_q <= RD_LAT'({first_pipe_q, rd_en_q && (k_q == '0)});
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign rd_en     = rd_en_q;
   assign row_addr  = k_q;
   assign feat_col  = i_q;
   assign wgt_col   = j_q;
   assign mac_en    = en_pipe_q[RD_LAT-1];
   assign mac_first = first_pipe_q[RD_LAT-1];
   assign acc_wr    = acc_wr_q;
   assign acc_idx   = e_q;
   assign out_valid = out_valid_q;
   assign out_idx   = d_q;

`ifdef GCN_SEQ_PERF_EN
   logic [15:0] perf_cycles_q, perf_stall_q;

   // Saturating counters; restart on start acceptance, survive abort
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cycles_q <= '0;
         perf_stall_q  <= '0;
      end else if (start_acc_c) begin
         perf_cycles_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         if ((state_q != S_IDLE) && (perf_cycles_q != 16'hFFFF)) begin
            perf_cycles_q <= perf_cycles_q + 16'd1;
         end
         if ((state_q == S_DRAIN) && !out_ready && (perf_stall_q != 16'hFFFF)) begin
            perf_stall_q <= perf_stall_q + 16'd1;
         end
      end
   end

   assign perf_cycles = perf_cycles_q;
   assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_gcn_mac_sequencer.sv
// Bench for gcn_mac_sequencer: default instance checked against a table of hand-computed
// vectors, plus an RD_LAT=3 instance sharing the same stimulus.
module tb_gcn_mac_sequencer;

   typedef struct {
      string      name;
      int         cyc;
      logic       busy;
      logic       rd_en;
      logic [6:0] row;
      logic [1:0] fc;
      logic [1:0] wc;
      logic       me;
      logic       mf;
      logic       aw;
      logic [3:0] ai;
      logic       ov;
      logic [3:0] oi;
      logic       dn;
   } vec_t;

   logic clk;
   logic rst_n, start, abort, out_ready;

   logic       busy1, dn1, rd1, me1, mf1, aw1, ov1;
   logic [6:0] row1;
   logic [1:0] fc1, wc1;
   logic [3:0] ai1, oi1;
   logic       busy3, dn3, rd3, me3, mf3, aw3, ov3;
   logic [6:0] row3;
   logic [1:0] fc3, wc3;
   logic [3:0] ai3, oi3;
`ifdef GCN_SEQ_PERF_EN
   logic [15:0] pc1, ps1, pc3, ps3;
`endif

   logic [25:0] obs1, obs3;
   assign obs1 = {busy1, rd1, row1, fc1, wc1, me1, mf1, aw1, ai1, ov1, oi1, dn1};
   assign obs3 = {busy3, rd3, row3, fc3, wc3, me3, mf3, aw3, ai3, ov3, oi3, dn3};

   gcn_mac_sequencer dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .busy(busy1), .done(dn1), .rd_en(rd1), .row_addr(row1),
      .feat_col(fc1), .wgt_col(wc1), .mac_en(me1), .mac_first(mf1),
      .acc_wr(aw1), .acc_idx(ai1), .out_valid(ov1), .out_ready(out_ready),
      .out_idx(oi1)
`ifdef GCN_SEQ_PERF_EN
      , .perf_cycles(pc1), .perf_stall(ps1)
`endif
   );

   gcn_mac_sequencer #(.RD_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .busy(busy3), .done(dn3), .rd_en(rd3), .row_addr(row3),
      .feat_col(fc3), .wgt_col(wc3), .mac_en(me3), .mac_first(mf3),
      .acc_wr(aw3), .acc_idx(ai3), .out_valid(ov3), .out_ready(out_ready),
      .out_idx(oi3)
`ifdef GCN_SEQ_PERF_EN
      , .perf_cycles(pc3), .perf_stall(ps3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   vec_t tbl[$];

   int         n_rd, lag_bad, n_mf, mf_bad, n_aw, done_c1;
   int         lag3_bad, aw3_first, done_c3;
   logic [2:0] h3;
   logic       rd_prev;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic add(input string n, input int c, input int b, input int rd, input int row,
                      input int fc, input int wc, input int me, input int mf, input int aw,
                      input int ai, input int ov, input int oi, input int dn);
      vec_t v;
      v.name = n;   v.cyc = c;
      v.busy = 1'(b);  v.rd_en = 1'(rd); v.row = 7'(row);
      v.fc = 2'(fc);   v.wc = 2'(wc);
      v.me = 1'(me);   v.mf = 1'(mf);    v.aw = 1'(aw);   v.ai = 4'(ai);
      v.ov = 1'(ov);   v.oi = 4'(oi);    v.dn = 1'(dn);
      tbl.push_back(v);
   endtask

   function automatic logic [25:0] pk(vec_t v);
      return {v.busy, v.rd_en, v.row, v.fc, v.wc, v.me, v.mf, v.aw, v.ai, v.ov, v.oi, v.dn};
   endfunction

   // Start a job, then run ncyc cycles counted from the first ISSUE cycle
   task automatic run(input int ncyc, input int restart_at, input int abort_at, input int tbl_lim);
      int ti;
      ti = 0;
      n_rd = 0; lag_bad = 0; n_mf = 0; mf_bad = 0; n_aw = 0; done_c1 = -1;
      lag3_bad = 0; aw3_first = -1; done_c3 = -1; h3 = '0; rd_prev = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         while (ti < tbl.size() && tbl[ti].cyc == c) begin
            if (c < tbl_lim) chk(tbl[ti].name, 32'(obs1), 32'(pk(tbl[ti])));
            ti++;
         end
         if (rd1) n_rd++;
         if (me1 !== rd_prev) lag_bad++;
         rd_prev = rd1;
         if (mf1) n_mf++;
         if (mf1 && !me1) mf_bad++;
         if (aw1) begin
            if (n_aw < 9)
               chk($sformatf("acc_wr%0d", n_aw),
                   32'(c * 256 + int'(ai1) * 16 + int'(fc1) * 4 + int'(wc1)),
                   32'((97 + 98 * n_aw) * 256 + n_aw * 16 + (n_aw / 3) * 4 + n_aw % 3));
            n_aw++;
         end
         if (dn1) done_c1 = c;
         if (me3 !== h3[2]) lag3_bad++;
         h3 = {h3[1:0], rd3};
         if (aw3 && aw3_first < 0) aw3_first = c;
         if (dn3) done_c3 = c;
         start = (c == restart_at) || (restart_at >= 0 && c == 891);
         abort = (c == abort_at);
         step();
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((busy1 || busy3) && t < 300) begin
         step();
         t++;
      end
      chk("idle_timeout", 32'(busy1 | busy3), 32'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int ev;
      // fields: busy rd_en row fc wc mac_en mac_first acc_wr acc_idx out_valid out_idx done
      add("first_issue",   0, 1,1, 0, 0,0, 0,0,0, 0, 0,0, 0);
      add("first_mac",     1, 1,1, 1, 0,0, 1,1,0, 0, 0,0, 0);
      add("second_mac",    2, 1,1, 2, 0,0, 1,0,0, 0, 0,0, 0);
      add("last_issue",   95, 1,1,95, 0,0, 1,0,0, 0, 0,0, 0);
      add("flush",        96, 1,0, 0, 0,0, 1,0,0, 0, 0,0, 0);
      add("wb_e0",        97, 1,0, 0, 0,0, 0,0,1, 0, 0,0, 0);
      add("issue_e1",     98, 1,1, 0, 0,1, 0,0,0, 1, 0,0, 0);
      add("mac_e1",       99, 1,1, 1, 0,1, 1,1,0, 1, 0,0, 0);
      add("wb_e1",       195, 1,0, 0, 0,1, 0,0,1, 1, 0,0, 0);
      add("wb_e3",       391, 1,0, 0, 1,0, 0,0,1, 3, 0,0, 0);
      add("wb_e8",       881, 1,0, 0, 2,2, 0,0,1, 8, 0,0, 0);
      add("drain_d0",    882, 1,0, 0, 0,0, 0,0,0, 0, 1,0, 0);
      add("drain_d4",    886, 1,0, 0, 0,0, 0,0,0, 0, 1,4, 0);
      add("drain_d8",    890, 1,0, 0, 0,0, 0,0,0, 0, 1,8, 0);
      add("done",        891, 1,0, 0, 0,0, 0,0,0, 0, 0,0, 1);
      add("idle_after",  892, 0,0, 0, 0,0, 0,0,0, 0, 0,0, 0);

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      repeat (3) step();
      chk("reset1", 32'(obs1), 32'(0));
      chk("reset3", 32'(obs3), 32'(0));
      rst_n = 1'b1;
      step();

      // Plain run, drain always ready
      run(912, -1, -1, 1000);
      chk("n_rd_en", 32'(n_rd), 32'(864));
      chk("mac_lag1", 32'(lag_bad), 32'(0));
      chk("n_mac_first", 32'(n_mf), 32'(9));
      chk("first_wo_en", 32'(mf_bad), 32'(0));
      chk("n_acc_wr", 32'(n_aw), 32'(9));
      chk("done_cyc", 32'(done_c1), 32'(891));
      chk("mac_lag3", 32'(lag3_bad), 32'(0));
      chk("l3_first_wr", 32'(aw3_first), 32'(99));
      chk("l3_done_cyc", 32'(done_c3), 32'(909));
      wait_idle();

      // start re-pulsed while busy and during DONE
      run(912, 300, -1, 1000);
      chk("restart_n_aw", 32'(n_aw), 32'(9));
      chk("restart_done", 32'(done_c1), 32'(891));
      chk("restart_l3_done", 32'(done_c3), 32'(909));
      wait_idle();

      // Drain stalled for 5 cycles at d=4
      run(886, -1, -1, 886);
      for (int s = 0; s < 5; s++) begin
         chk($sformatf("stall_hold%0d", s), 32'({ov1, oi1}), 32'h14);
         out_ready = 1'b0;
         step();
      end
      chk("stall_release", 32'({ov1, oi1}), 32'h14);
      out_ready = 1'b1;
      step();
      repeat (3) step();
      chk("stall_d8", 32'({ov1, oi1}), 32'h18);
      step();
      chk("stall_done", 32'({busy1, dn1}), 32'h3);
      step();
      chk("stall_idle", 32'({busy1, dn1}), 32'h0);
`ifdef GCN_SEQ_PERF_EN
      chk("perf_stall", 32'(ps1), 32'(5));
      chk("perf_cycles", 32'(pc1), 32'(897));
      chk("perf_stall3", 32'(ps3), 32'(0));
      chk("perf_cycles3", 32'(pc3), 32'(897));
`endif
      wait_idle();

      // Abort in ISSUE of element 3 with k=40
      run(335, -1, 334, 0);
      chk("abort_obs", 32'(obs1), 32'(0));
      chk("abort_n_aw", 32'(n_aw), 32'(3));
      ev = 0;
      repeat (50) begin
         step();
         if (aw1 || dn1 || busy1 || me1) ev++;
      end
      chk("abort_quiet", 32'(ev), 32'(0));

      start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      chk("start_abort_idle", 32'({busy1, busy3}), 32'(0));

      // Fresh start after abort begins again at element 0
      run(100, -1, -1, 100);
      chk("restart_first_wr", 32'(n_aw), 32'(1));
      abort = 1'b1;
      step();
      abort = 1'b0;
      wait_idle();

      // RD_LAT=3 instance reset asynchronously during DRAIN
      run(903, -1, -1, 0);
      chk("l3_in_drain", 32'({busy3, ov3}), 32'h3);
      rst_n = 1'b0;
      #1;
      chk("l3_async_rst", 32'(obs3), 32'(0));
      chk("async_rst1", 32'(obs1), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/gcn_mac_sequencer.md
Name: gcn_mac_sequencer

Overview:
- Control FSM for the GCN feature×weight MAC datapath.
- Computes Res[i][j] = sum over k of F[k][i]·W[k][j] for k = 0..ROWS-1.
- For each of the COLS×COLS output elements it issues row addresses to the feature and weight buffers, drives the accumulator enables, commits each finished sum to the result buffer, then drains the results downstream over a valid/ready handshake.
- Sits between the host start/done interface and the F/W buffers plus the shared 17-bit accumulator. It carries no datapath values.

Parameters:
- ROWS, 96: reduction length k.
- COLS, 3: feature/weight columns; the output is COLS×COLS.
- RD_LAT, 1: buffer read latency in cycles (valid values 1..3).
- ROW_W, 7: width of the row address (≥ clog2(ROWS)).
- COL_W, 2: width of the column address (≥ clog2(COLS)).
- IDX_W, 4: width of the result index (≥ clog2(COLS·COLS)).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  start request; accepted only in IDLE
- abort  in  1  synchronous abort
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last result is drained
- rd_en  out  1  buffer read strobe
- row_addr  out  ROW_W  k, shared by the F and W buffers
- feat_col  out  COL_W  i (feature column)
- wgt_col  out  COL_W  j (weight column)
- mac_en  out  1  accumulate the product on this cycle
- mac_first  out  1  with mac_en: load the product instead of adding
- acc_wr  out  1  write the accumulator to the result buffer
- acc_idx  out  IDX_W  write index, i·COLS + j
- out_valid  out  1  drain data valid
- out_ready  in  1  downstream ready
- out_idx  out  IDX_W  result-buffer read index during drain

Behaviour:
- Reset: every output is 0; the FSM is in IDLE; all counters are 0.
- States: IDLE, ISSUE, FLUSH, WB, DRAIN, DONE.
- IDLE → ISSUE when start = 1. Counters k, i, j are cleared.
- ISSUE:
  - rd_en = 1, row_addr = k, feat_col = i, wgt_col = j.
  - k increments each cycle.
  - When k = ROWS-1: k wraps to 0 and the FSM moves to FLUSH.
- Accumulate pipeline:
  - A delay line of depth RD_LAT carries (rd_en, k==0).
  - mac_en and mac_first are asserted exactly RD_LAT cycles after the matching issue cycle.
  - mac_first = 1 only for k = 0, so no separate accumulator clear is needed.
- FLUSH: lasts exactly RD_LAT cycles with rd_en = 0. The last mac_en fires in its final cycle. Then → WB.
- WB (1 cycle):
  - acc_wr = 1, acc_idx = i·COLS + j.
  - j increments; when j wraps, i increments.
  - If i = COLS-1 and j = COLS-1 → DRAIN; otherwise → ISSUE.
- Element order: i outer, j inner. acc_idx sequence is 0, 1, …, COLS²-1.
- Cycles per element: ROWS + RD_LAT + 1 (98 at defaults). The first DRAIN cycle is 9·98 = 882 cycles after start acceptance.
- DRAIN:
  - out_valid = 1, out_idx = d, starting at d = 0.
  - d increments on out_valid && out_ready.
  - When d = COLS²-1 is accepted → DONE.
  - out_idx holds its value while out_ready = 0.
  - out_valid is never deasserted without a handshake, except on abort.
- DONE: done = 1 for one cycle, then → IDLE. busy drops in the same cycle done drops.
- start while busy: ignored, no queuing. start asserted in the DONE cycle is ignored.
- abort:
  - In any non-IDLE state: next state is IDLE, and all strobes, the delay line and the counters are cleared.
  - done is not asserted.
  - abort takes priority over every other transition. abort in IDLE has no effect.
  - abort and start together in IDLE: start is ignored.
- rst_n asserted mid-operation: immediate return to the reset values. There is no partial-result recovery.
- Counters saturate nowhere. The ISSUE/WB/DRAIN logic guarantees k < ROWS, i and j < COLS, and d < COLS².

Optional Feature:
- Macro: GCN_SEQ_PERF_EN.
- When defined:
  - Extra outputs perf_cycles (out, 16) and perf_stall (out, 16).
  - perf_cycles counts cycles from start acceptance up to and including the DONE cycle.
  - perf_stall counts DRAIN cycles with out_ready = 0.
  - Both counters clear on start acceptance, hold after done, saturate at 0xFFFF, and are not cleared by abort.
- When not defined: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Defaults, start pulse, out_ready tied to 1:
  - 96 rd_en cycles per element, row_addr 0..95.
  - mac_first coincides with the first mac_en.
  - acc_wr at cycles 97, 195, …, 881 with acc_idx 0..8.
  - out_idx 0..8 on cycles 882..890; done at 891.
- Check the ordering of (feat_col, wgt_col) at each acc_wr: (0,0), (0,1), (0,2), (1,0), …, (2,2).
- Stalled drain: out_ready = 0 for 5 cycles at d = 4. Expect out_valid held high, out_idx = 4 held, and done delayed by 5 cycles; with GCN_SEQ_PERF_EN, perf_stall = 5 and perf_cycles = 897.
- start re-pulsed at cycle 300 → no effect; the acc_wr and done timing match the first scenario.
- abort in ISSUE with k = 40, element 3 → next cycle busy = 0, mac_en = 0, no acc_wr and no done. A new start then produces acc_idx 0 first.
- RD_LAT = 3:
  - Each mac_en lags its rd_en by exactly 3 cycles.
  - Per-element period is 100 cycles; the first acc_wr is at cycle 99; done is at cycle 909.
  - rst_n is pulsed low during DRAIN → all outputs are 0 immediately.
